// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory: access sizes, FSM states, counter width.
package data_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   localparam int CNT_W = 8;

endpackage

// File: rtl/data_mem_if.sv
// Request/response bus between the core (master) and the data memory (slave).
interface data_mem_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req;
   logic                  we;
   logic [1:0]            size;
   logic                  sign_ext;
   logic [ADDR_WIDTH-1:0] address;
   logic [31:0]           writedata;
   logic                  ready;
   logic                  done;
   logic [31:0]           readdata;
   logic                  err;

   modport master (
      output req, we, size, sign_ext, address, writedata,
      input  ready, done, readdata, err
   );

   modport slave (
      input  req, we, size, sign_ext, address, writedata,
      output ready, done, readdata, err
   );
endinterface

// File: rtl/data_mem_byte_lane_align.sv
// Maps byte/half/word accesses onto the four byte lanes of a 32-bit word,
// producing the write lane mask, the lane-aligned write data and the
// right-aligned, extended load value.
module byte_lane_align
   import data_mem_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        sign_ext,
   input  logic [31:0] old_word,
   input  logic [31:0] writedata,
   output logic [3:0]  lane_mask,
   output logic [31:0] write_word,
   output logic [31:0] load_value
);

   logic [1:0]  lane;
   logic [4:0]  shamt;
   logic [31:0] shifted;

   // Lane 0 is bits 7:0; 'lane' is the least significant lane touched.
   always_comb begin
      lane       = '0;
      lane_mask  = '1;
      write_word = writedata;
      load_value = '0;
      case (size)
         SZ_BYTE: begin
            lane       = BIG_ENDIAN ? 2'd3 - offset : offset;
            lane_mask  = 4'b0001 << lane;
            write_word = {24'h0, writedata[7:0]};
         end
         SZ_HALF: begin
            lane       = BIG_ENDIAN ? 2'd2 - offset : offset;
            lane_mask  = 4'b0011 << lane;
            write_word = {16'h0, writedata[15:0]};
         end
         default: begin
            lane      = '0;
            lane_mask = '1;
         end
      endcase
      shamt      = {lane, 3'b000};
      write_word = write_word << shamt;
      shifted    = old_word >> shamt;
      case (size)
         SZ_BYTE: load_value = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_value = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         default: load_value = shifted;
      endcase
   end

endmodule

// File: rtl/data_mem.sv
// Single-port byte-addressable data memory with wait states, selectable
// endianness and error reporting for misaligned / reserved / out-of-range
// accesses.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 2,
  parameter int    BIG_ENDIAN  = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic      clock,
  input  logic      reset_n,
  data_mem_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic                  we_q;
  logic                  sx_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wd_q;

  logic [ADDR_WIDTH-2:0] word_idx;
  logic                  in_range;
  logic                  bad;
  logic                  fire;
  logic [31:0]           old_word;
  logic [3:0]            lane_mask;
  logic [31:0]           bit_mask;
  logic [31:0]           write_word;
  logic [31:0]           load_value;
  logic [31:0]           merged;

  // Zero-extended by one bit so DEPTH == 2^(ADDR_WIDTH-2) still fits the compare.
  assign word_idx = {1'b0, addr_q[ADDR_WIDTH-1:2]};
  assign in_range = word_idx < (ADDR_WIDTH-1)'(DEPTH);
  assign old_word = in_range ? mem[word_idx[IW-1:0]] : '0;

  assign bad = (size_q == SZ_RSVD)
            || (size_q == SZ_HALF && addr_q[0])
            || (size_q == SZ_WORD && addr_q[1:0] != 2'b00)
            || !in_range;

  assign fire      = (state == WAIT) && (cnt == '0);
  assign bus.ready = (state == IDLE);

  byte_lane_align #(
    .BIG_ENDIAN (BIG_ENDIAN != 0)
  ) u_align (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .sign_ext   (sx_q),
    .old_word   (old_word),
    .writedata  (wd_q),
    .lane_mask  (lane_mask),
    .write_word (write_word),
    .load_value (load_value)
  );

  assign bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}},
                     {8{lane_mask[1]}}, {8{lane_mask[0]}}};
  assign merged   = (old_word & ~bit_mask) | (write_word & bit_mask);

  // Elaboration-time clear; memory is never touched by reset.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Request capture; these registers only matter while an access is pending.
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.req) begin
      we_q   <= bus.we;
      sx_q   <= bus.sign_ext;
      size_q <= bus.size;
      addr_q <= bus.address;
      wd_q   <= bus.writedata;
    end
  end

  // FSM, wait-state counter and registered response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.done     <= 1'b0;
      bus.readdata <= '0;
      bus.err      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            state <= WAIT;
            cnt   <= CNT_W'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state        <= IDLE;
            bus.done     <= 1'b1;
            bus.err      <= bad;
            bus.readdata <= (bad || we_q) ? '0 : load_value;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store commit; reset forces IDLE so an abandoned access never writes.
  always_ff @(posedge clock) begin
    if (fire && we_q && !bad) mem[word_idx[IW-1:0]] <= merged;
  end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: three instances (big-endian default,
// little-endian, zero wait states) driven by one directed sequence.
module tb_data_mem;
   import data_mem_pkg::*;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          cyc;
      string       tag;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   exp_t q[3][$];
   int   wcyc[3] = '{2, 2, 0};

   always #5 clock = ~clock;

   // Edge counter used to time each done against its accept edge.
   always @(posedge clock) cyc <= cyc + 1;

   data_mem_if #(.ADDR_WIDTH(32)) b0 ();
   data_mem_if #(.ADDR_WIDTH(32)) b1 ();
   data_mem_if #(.ADDR_WIDTH(32)) b2 ();

   data_mem #(.WAIT_CYCLES(2), .BIG_ENDIAN(1)) d0 (.clock(clock), .reset_n(reset_n), .bus(b0));
   data_mem #(.WAIT_CYCLES(2), .BIG_ENDIAN(0)) d1 (.clock(clock), .reset_n(reset_n), .bus(b1));
   data_mem #(.WAIT_CYCLES(0), .BIG_ENDIAN(1)) d2 (.clock(clock), .reset_n(reset_n), .bus(b2));

   task automatic drive(input int sel, input logic rq, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd);
      case (sel)
         0: begin b0.req = rq; b0.we = w; b0.size = sz; b0.sign_ext = sx; b0.address = a; b0.writedata = wd; end
         1: begin b1.req = rq; b1.we = w; b1.size = sz; b1.sign_ext = sx; b1.address = a; b1.writedata = wd; end
         default: begin b2.req = rq; b2.we = w; b2.size = sz; b2.sign_ext = sx; b2.address = a; b2.writedata = wd; end
      endcase
   endtask

   task automatic sample(input int sel, output logic rdy, output logic dn,
                         output logic [31:0] rd, output logic er);
      case (sel)
         0: begin rdy = b0.ready; dn = b0.done; rd = b0.readdata; er = b0.err; end
         1: begin rdy = b1.ready; dn = b1.done; rd = b1.readdata; er = b1.err; end
         default: begin rdy = b2.ready; dn = b2.done; rd = b2.readdata; er = b2.err; end
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      logic rdy, dn, er;
      logic [31:0] rd;
      exp_t e;
      for (int sel = 0; sel < 3; sel++) begin
         sample(sel, rdy, dn, rd, er);
         if (dn === 1'b1) begin
            checks++;
            assert (q[sel].size() != 0) else begin
               errors++;
               $error("FAIL dut%0d unexpected done: observed no pending access expected none", sel);
            end
            if (q[sel].size() != 0) begin
               e = q[sel].pop_front();
               check({e.tag, " readdata"}, rd, e.rd);
               check({e.tag, " err"}, {31'h0, er}, {31'h0, e.err});
               check({e.tag, " latency"}, 32'(cyc), 32'(e.cyc));
               check({e.tag, " ready_with_done"}, {31'h0, rdy}, 32'd1);
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clock);
      monitor();
   endtask

   task automatic issue(input int sel, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input string tag,
                        input bit track = 1'b1);
      logic rdy, dn, er;
      logic [31:0] rd;
      bit acc = 1'b0;
      exp_t e;
      drive(sel, 1'b1, w, sz, sx, a, wd);
      for (int n = 0; n < 20 && !acc; n++) begin
         sample(sel, rdy, dn, rd, er);
         if (rdy) begin
            @(posedge clock);
            #1;
            acc = 1'b1;
            if (track) begin
               e.rd = erd; e.err = eerr; e.cyc = cyc + wcyc[sel] + 1; e.tag = tag;
               q[sel].push_back(e);
            end
            // Scramble inputs: the pending access must not notice.
            drive(sel, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
         end
         tick();
      end
      checks++;
      assert (acc) else begin
         errors++;
         $error("FAIL %s accept: observed no accept expected accept within 20 cycles", tag);
      end
      if (track) begin
         for (int n = 0; n < 20 && q[sel].size() != 0; n++) tick();
         checks++;
         assert (q[sel].size() == 0) else begin
            errors++;
            $error("FAIL %s done_timeout: observed %0d pending expected 0", tag, q[sel].size());
            q[sel].delete();
         end
      end
   endtask

   initial begin
      logic rdy, dn, er;
      logic [31:0] rd;
      logic [31:0] vals[4];
      int prev;
      bit got;
      exp_t e;

      vals = '{32'hA1B2C3D4, 32'h00000001, 32'h80000000, 32'hFFFFFFFF};
      prev = 0;
      for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
      repeat (3) tick();
      for (int s = 0; s < 3; s++) begin
         sample(s, rdy, dn, rd, er);
         check($sformatf("dut%0d reset ready", s), {31'h0, rdy}, 32'd1);
         check($sformatf("dut%0d reset done", s), {31'h0, dn}, 32'd0);
         check($sformatf("dut%0d reset readdata", s), rd, 32'h0);
         check($sformatf("dut%0d reset err", s), {31'h0, er}, 32'd0);
      end
      reset_n = 1'b1;
      tick();

      // Big-endian, two wait states.
      issue(0, 1, SZ_WORD, 0, 32'h10, 32'h11223344, 32'h0, 0, "sw_10");
      issue(0, 0, SZ_BYTE, 0, 32'h11, 32'h0, 32'h00000022, 0, "lbu_11");
      issue(0, 0, SZ_HALF, 0, 32'h12, 32'h0, 32'h00003344, 0, "lhu_12");
      issue(0, 1, SZ_BYTE, 0, 32'h13, 32'h80, 32'h0, 0, "sb_13");
      issue(0, 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0, "lb_13");
      issue(0, 0, SZ_HALF, 0, 32'h12, 32'h0, 32'h00003380, 0, "lhu_12b");
      issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h11223380, 0, "lw_10");
      issue(0, 0, SZ_WORD, 0, 32'h12, 32'h0, 32'h0, 1, "lw_mis");
      issue(0, 1, SZ_HALF, 0, 32'h11, 32'hBEEF, 32'h0, 1, "sh_mis");
      issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h11223380, 0, "lw_after_sh_mis");
      issue(0, 0, SZ_WORD, 0, 32'h1000, 32'h0, 32'h0, 1, "lw_depth");
      issue(0, 1, SZ_WORD, 0, 32'h1000, 32'h12345678, 32'h0, 1, "sw_depth");
      issue(0, 0, SZ_RSVD, 0, 32'h10, 32'h0, 32'h0, 1, "ld_rsvd");
      issue(0, 1, SZ_RSVD, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 1, "st_rsvd");
      issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h11223380, 0, "lw_after_rsvd");
      issue(0, 1, SZ_HALF, 0, 32'h10, 32'hAAAA5566, 32'h0, 0, "sh_10");
      issue(0, 1, SZ_BYTE, 0, 32'h11, 32'hFFFFFFA5, 32'h0, 0, "sb_11");
      issue(0, 0, SZ_HALF, 1, 32'h10, 32'h0, 32'h000055A5, 0, "lh_10");
      issue(0, 0, SZ_BYTE, 1, 32'h11, 32'h0, 32'hFFFFFFA5, 0, "lb_11");
      issue(0, 0, SZ_BYTE, 0, 32'h11, 32'h0, 32'h000000A5, 0, "lbu_11b");
      issue(0, 1, SZ_HALF, 0, 32'h12, 32'h8001, 32'h0, 0, "sh_12");
      issue(0, 0, SZ_HALF, 1, 32'h12, 32'h0, 32'hFFFF8001, 0, "lh_12");
      issue(0, 0, SZ_HALF, 0, 32'h12, 32'h0, 32'h00008001, 0, "lhu_12c");
      issue(0, 0, SZ_WORD, 1, 32'h10, 32'h0, 32'h55A58001, 0, "lw_sx_10");
      repeat (3) tick();
      sample(0, rdy, dn, rd, er);
      check("readdata_hold", rd, 32'h55A58001);
      check("done_low_after_pulse", {31'h0, dn}, 32'd0);

      // Reset one cycle after accepting a store: no done, no write.
      issue(0, 1, SZ_WORD, 0, 32'h20, 32'hDEADBEEF, 32'h0, 0, "rst_sw", 1'b0);
      reset_n = 1'b0;
      tick();
      sample(0, rdy, dn, rd, er);
      check("mid_reset ready", {31'h0, rdy}, 32'd1);
      check("mid_reset readdata", rd, 32'h0);
      reset_n = 1'b1;
      repeat (5) tick();
      sample(0, rdy, dn, rd, er);
      check("post_reset done", {31'h0, dn}, 32'd0);
      issue(0, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h0, 0, "lw_20_after_reset");
      issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h55A58001, 0, "lw_10_kept");

      // Little-endian instance.
      issue(1, 1, SZ_WORD, 0, 32'h0, 32'h11223344, 32'h0, 0, "le_sw_0");
      issue(1, 0, SZ_BYTE, 0, 32'h0, 32'h0, 32'h00000044, 0, "le_lbu_0");
      issue(1, 0, SZ_HALF, 1, 32'h2, 32'h0, 32'h00001122, 0, "le_lh_2");
      issue(1, 1, SZ_BYTE, 0, 32'h1, 32'h99, 32'h0, 0, "le_sb_1");
      issue(1, 0, SZ_WORD, 0, 32'h0, 32'h0, 32'h11229944, 0, "le_lw_0");
      issue(1, 0, SZ_BYTE, 1, 32'h1, 32'h0, 32'hFFFFFF99, 0, "le_lb_1");
      issue(1, 0, SZ_HALF, 0, 32'h0, 32'h0, 32'h00009944, 0, "le_lhu_0");

      // Zero wait states: fill four words, then stream loads with req held.
      for (int k = 0; k < 4; k++)
         issue(2, 1, SZ_WORD, 0, 32'(k * 4), vals[k], 32'h0, 0, $sformatf("w0_sw_%0d", k));
      drive(2, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int n = 0; n < 10 && !got; n++) begin
            sample(2, rdy, dn, rd, er);
            if (rdy) begin
               @(posedge clock);
               #1;
               got = 1'b1;
               e.rd = vals[k]; e.err = 1'b0; e.cyc = cyc + 1; e.tag = $sformatf("held_lw_%0d", k);
               q[2].push_back(e);
               if (k > 0) check("held_accept_spacing", 32'(cyc - prev), 32'd2);
               prev = cyc;
               if (k < 3) drive(2, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'((k + 1) * 4), 32'h0);
               else       drive(2, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
            end
            tick();
         end
         checks++;
         assert (got) else begin
            errors++;
            $error("FAIL held_accept_%0d: observed no accept expected accept", k);
         end
      end
      for (int n = 0; n < 10 && q[2].size() != 0; n++) tick();
      repeat (4) tick();
      checks++;
      assert (q[2].size() == 0) else begin
         errors++;
         $error("FAIL held_drain: observed %0d pending expected 0", q[2].size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
